// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the wireless-link UART. Both the byte receiver
// (uart_rx_byte) and the byte transmitter import this package, so the frame
// format and line polarity are defined in exactly one place.
//
// Contents:
//   rx_state_t  receiver frame state
//   DATA_BITS   data bits per frame (8N1)
//   LINE_IDLE   level of an idle serial line (also the stop-bit level)
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,   // line idle, waiting for a falling edge
    START,  // timing to the middle of the start bit
    DATA,   // sampling the data bits at mid-bit
    STOP,   // sampling the stop bit at mid-bit
    BREAK   // stop bit was low; wait for the line to return high
  } rx_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// One-bit, two-flop synchronizer for bringing an asynchronous level into the
// clk domain. The output lags the input by two clk cycles. The reset value is
// a parameter so an idle-high line (UART RX) or idle-low line (keypad rows)
// does not show a spurious edge when reset is released.
//
// Parameters:
//   RESET_VAL  value both flops take while rst is high
//
// Ports:
//   clk  in   system clock
//   rst  in   synchronous, active-high reset
//   d_i  in   asynchronous input
//   q_o  out  synchronized output
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments make meta_q -> sync_q a true two-stage
  // pipeline; blocking here would collapse both flops into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 serial receiver for the host/player wireless link. Recovers frames from
// the radio module's RX pin, holds each good byte in a one-deep register with
// a valid/ack handshake toward the game FSM, and pulses framing/overrun error
// flags for the top-level error indication.
//
// Bit timing: after the synchronized line falls, the receiver waits half a bit
// and re-checks the start bit (rejecting short glitches), then samples each
// data bit and the stop bit one full bit period later, i.e. at mid-bit.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per bit (even, >= 4); 1250 = 12 MHz / 9600
//   CNT_W         bit-timing counter width (derived)
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   rx           in   asynchronous serial line, idles high
//   data_ack     in   consumer has taken data; sampled every cycle
//   data         out  last good received byte
//   data_valid   out  data holds an unconsumed byte
//   busy         out  a frame is in progress
//   framing_err  out  one-cycle pulse: stop bit sampled low
//   overrun_err  out  one-cycle pulse: good byte dropped, holding reg full
// -----------------------------------------------------------------------------
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 1250,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       data_ack,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       busy,
  output logic       framing_err,
  output logic       overrun_err
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizer: resets to the idle level so reset release is not
  // mistaken for a start bit.
  // ---------------------------------------------------------------------------
  logic rx_s;

  sync_2ff #(
    .RESET_VAL (LINE_IDLE)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  rx_state_t  state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0] bit_idx_q;
  logic [7:0] shift_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic       framing_err_q;
  logic       overrun_err_q;

  logic [7:0] shift_d;
  logic       cnt_half;
  logic       cnt_full;
  logic       bit_last;
  logic       line_high;

  // Bits arrive LSB first: each new sample enters at the MSB and the byte is
  // aligned once all eight have been shifted in.
  assign shift_d   = {rx_s, shift_q[7:1]};
  assign cnt_half  = (cnt_q == HALF_LAST);
  assign cnt_full  = (cnt_q == FULL_LAST);
  assign bit_last  = (bit_idx_q == BIT_LAST);
  assign line_high = (rx_s == LINE_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      data_q        <= 8'h00;
      valid_q       <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      // Error flags are single-cycle pulses.
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;

      // NOTE: within one always_ff the last non-blocking assignment to a
      // register wins, so a commit in STOP below overrides this ack-clear.
      if (data_ack) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!line_high) begin
            state_q <= START;
          end
        end

        START: begin
          if (cnt_half) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // Line back high at mid start bit: a glitch, not a frame.
            state_q   <= line_high ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_full) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            if (bit_last) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt_full) begin
            cnt_q <= '0;
            if (line_high) begin
              state_q <= IDLE;
              // Commit: accept if the holding register is empty or is being
              // emptied this very cycle; otherwise keep the old byte.
              if (!valid_q || data_ack) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_err_q <= 1'b1;
              end
            end else begin
              framing_err_q <= 1'b1;
              state_q       <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        BREAK: begin
          // A held-low line must not be decoded as a stream of frames.
          cnt_q <= '0;
          if (line_high) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign data        = data_q;
  assign data_valid  = valid_q;
  assign busy        = (state_q != IDLE);
  assign framing_err = framing_err_q;
  assign overrun_err = overrun_err_q;

endmodule : uart_rx_byte

// File: tb/tb_uart_rx_byte.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_byte
// Scoreboard bench for uart_rx_byte at CLKS_PER_BIT = 16. Stimulus tasks push
// the expected byte and its expected commit cycle into a queue; a monitor
// pops and compares whenever the DUT presents a new byte, and tallies the
// error pulses.
//
// Commit timing for a frame whose start bit is driven right after edge k:
//   2 sync edges + 1 detect edge + 8 (half bit) + 9 * 16 (data + stop) = 155,
// so data_valid is seen high right after edge k + 155.
// -----------------------------------------------------------------------------
module tb_uart_rx_byte;

  localparam int CPB        = 16;
  localparam int FRAME      = 10 * CPB;
  localparam int COMMIT_OFS = 155;

  typedef struct {
    logic [7:0]  b;
    int unsigned c;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       ack_man;
  logic       ack_auto;
  logic       auto_en;
  logic       data_ack;
  logic [7:0] data;
  logic       data_valid;
  logic       busy;
  logic       framing_err;
  logic       overrun_err;

  int unsigned cyc;
  int          checks;
  int          errors;
  exp_t        exp_q[$];

  logic        prev_valid;
  logic [7:0]  prev_data;
  logic        prev_fe;
  logic        prev_ov;
  int          fe_pulses;
  int          fe_hi;
  int          ov_pulses;
  int          ov_hi;

  assign data_ack = ack_man | ack_auto;

  uart_rx_byte #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .data_ack    (data_ack),
    .data        (data),
    .data_valid  (data_valid),
    .busy        (busy),
    .framing_err (framing_err),
    .overrun_err (overrun_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: new byte = valid rising, or valid held while data changes
  // (commit with simultaneous ack). Also drives the optional auto-ack.
  // ---------------------------------------------------------------------------
  initial begin
    prev_valid = 1'b0;
    prev_data  = 8'h00;
    prev_fe    = 1'b0;
    prev_ov    = 1'b0;
    fe_pulses  = 0;
    fe_hi      = 0;
    ov_pulses  = 0;
    ov_hi      = 0;
    ack_auto   = 1'b0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && data_valid && (!prev_valid || data != prev_data)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %02h with no byte expected (cycle %0d)", data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("rx_byte", {24'h0, data}, {24'h0, e.b});
        check("rx_latency", cyc, e.c);
      end
    end
    ack_auto = auto_en && data_valid && !prev_valid;
    if (framing_err)             fe_hi++;
    if (framing_err && !prev_fe) fe_pulses++;
    if (overrun_err)             ov_hi++;
    if (overrun_err && !prev_ov) ov_pulses++;
    prev_valid = data_valid;
    prev_data  = data;
    prev_fe    = framing_err;
    prev_ov    = overrun_err;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame, one bit per CPB cycles. abort_at >= 0 pulses rst at
  // that cycle offset and leaves the line idle.
  task automatic send(input logic [7:0] b, input logic stop_bit, input bit expect_byte,
                      input bit ack_commit, input int abort_at);
    logic [9:0]  frame;
    int unsigned k;
    exp_t        e;
    frame = {stop_bit, b, 1'b0};
    k     = cyc;
    if (expect_byte) begin
      e.b = b;
      e.c = k + COMMIT_OFS;
      exp_q.push_back(e);
    end
    for (int c = 0; c < FRAME; c++) begin
      if (c == abort_at) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        rx  = 1'b1;
        return;
      end
      rx = frame[c / CPB];
      if (ack_commit) ack_man = (c == COMMIT_OFS - 1);
      tick(1);
    end
    ack_man = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
    check(name, exp_q.size(), 0);
  endtask

  task automatic pulse_ack();
    ack_man = 1'b1;
    tick(1);
    ack_man = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit seen;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    rx      = 1'b1;
    ack_man = 1'b0;
    auto_en = 1'b0;
    tick(3);
    check("reset_data",        {24'h0, data}, 32'h00);
    check("reset_valid",       data_valid,    0);
    check("reset_busy",        busy,          0);
    check("reset_framing_err", framing_err,   0);
    check("reset_overrun_err", overrun_err,   0);
    rst = 1'b0;
    tick(5);

    // Good byte, then ack clears valid the next cycle.
    send(8'h41, 1'b1, 1, 0, -1);
    drain("a_drained");
    check("a_valid", data_valid,    1);
    check("a_data",  {24'h0, data}, 32'h41);
    pulse_ack();
    check("a_ack_clears_valid", data_valid,    0);
    check("a_data_kept",        {24'h0, data}, 32'h41);

    // Back-to-back, auto-acked on the valid rising cycle.
    auto_en = 1'b1;
    send(8'h50, 1'b1, 1, 0, -1);
    send(8'h4C, 1'b1, 1, 0, -1);
    drain("btb_drained");
    tick(2);
    auto_en = 1'b0;
    check("btb_busy_done", busy,          0);
    check("btb_valid",     data_valid,    0);
    check("btb_data",      {24'h0, data}, 32'h4C);

    // Glitch: 4 clocks low is shorter than half a bit.
    seen = 0;
    rx   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) rx = 1'b1;
      tick(1);
      if (busy) seen = 1;
    end
    check("glitch_busy_seen", seen, 1);
    tick(10);
    check("glitch_busy_done", busy,       0);
    check("glitch_no_valid",  data_valid, 0);
    check("glitch_no_fe",     fe_pulses,  0);

    // Framing error then held-low line.
    send(8'h45, 1'b0, 0, 0, -1);
    tick(40);
    check("fe_in_break",   busy,          1);
    check("fe_one_pulse",  fe_pulses,     1);
    check("fe_valid_kept", data_valid,    0);
    check("fe_data_kept",  {24'h0, data}, 32'h4C);
    rx = 1'b1;
    tick(5);
    check("fe_break_exit", busy, 0);
    send(8'h52, 1'b1, 1, 0, -1);
    drain("after_fe_drained");
    check("after_fe_data", {24'h0, data}, 32'h52);
    pulse_ack();

    // Overrun: second byte dropped.
    send(8'h4D, 1'b1, 1, 0, -1);
    send(8'h4F, 1'b1, 0, 0, -1);
    tick(2);
    check("ov_one_pulse",  ov_pulses,     1);
    check("ov_data_kept",  {24'h0, data}, 32'h4D);
    check("ov_valid_kept", data_valid,    1);
    pulse_ack();
    check("ov_ack_clears", data_valid, 0);

    // Ack in the commit cycle: new byte accepted, no overrun.
    send(8'h4D, 1'b1, 1, 0, -1);
    send(8'h4F, 1'b1, 1, 1, -1);
    drain("simack_drained");
    check("simack_data",  {24'h0, data}, 32'h4F);
    check("simack_valid", data_valid,    1);
    check("simack_no_ov", ov_pulses,     1);

    // Reset during data bit 3 of 8'hAA.
    send(8'hAA, 1'b1, 0, 0, 70);
    check("rst_mid_data",  {24'h0, data}, 32'h00);
    check("rst_mid_valid", data_valid,    0);
    check("rst_mid_busy",  busy,          0);
    check("rst_mid_fe",    framing_err,   0);
    check("rst_mid_ov",    overrun_err,   0);
    tick(30);
    send(8'h48, 1'b1, 1, 0, -1);
    drain("h_drained");
    check("h_data",  {24'h0, data}, 32'h48);
    check("h_valid", data_valid,    1);

    check("fe_total",       fe_pulses, 1);
    check("ov_total",       ov_pulses, 1);
    check("fe_pulse_width", fe_hi,     fe_pulses);
    check("ov_pulse_width", ov_hi,     ov_pulses);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule : tb_uart_rx_byte
